// File: rtl/pmesh_msg_pkg.sv
// Shared P-Mesh message definitions: message types, field widths and the
// invalidation-forward responder state encoding.
package pmesh_msg_pkg;

    localparam int TYPE_W = 8;
    localparam int SRC_W  = 6;
    localparam int TAG_W  = 26;
    localparam int DATA_W = 64;

    localparam logic [TYPE_W-1:0] MSG_INV_FWD    = 8'h16;
    localparam logic [TYPE_W-1:0] MSG_INV_FWDACK = 8'h17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_ACK
    } rsp_state_t;

endpackage

// File: rtl/l1_line_store.sv
// Small direct-mapped L1 line store: tag/valid (and, with L1_INV_WRITEBACK_EN,
// dirty/data) arrays with one combinational read, one invalidate and one write port.
module l1_line_store
    import pmesh_msg_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_dirty,
    output logic [DATA_W-1:0] rd_data,
    input  logic              inv_en,
    input  logic [IDX_W-1:0]  inv_idx,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     line_tag [NUM_LINES];

    // Write follows invalidate so a write wins if both ever hit one index.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (inv_en) valid[inv_idx] <= 1'b0;
            if (wr_en)  valid[wr_idx]  <= 1'b1;
        end
    end

    // NOTE: payload arrays carry no reset; the valid bits alone decide whether
    // an entry means anything, so clearing tags/data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_en) line_tag[wr_idx] <= wr_tag;
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = line_tag[rd_idx];

`ifdef L1_INV_WRITEBACK_EN
    logic [NUM_LINES-1:0] dirty;
    logic [DATA_W-1:0]    line_data [NUM_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            dirty <= '0;
        end else begin
            if (inv_en) dirty[inv_idx] <= 1'b0;
            if (wr_en)  dirty[wr_idx]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) line_data[wr_idx] <= wr_data;
    end

    assign rd_dirty = dirty[rd_idx];
    assign rd_data  = line_data[rd_idx];
`else
    logic unused_wr_data;
    assign unused_wr_data = ^wr_data;
    assign rd_dirty       = 1'b0;
    assign rd_data        = '0;
`endif

endmodule

// File: rtl/l1_inv_fwd_responder.sv
// L1 responder for L2 INV_FWD requests: invalidates the local line and returns one
// INV_FWDACK per request. Define L1_INV_WRITEBACK_EN to return dirty data on ack_data.
module l1_inv_fwd_responder
    import pmesh_msg_pkg::*;
#(
    parameter int         NUM_LINES = 4,
    parameter logic [5:0] MY_ID     = 6'd0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [7:0]    req_type,
    input  logic [5:0]    req_source,
    input  logic [25:0]   req_tag,
    output logic          ack_valid,
    input  logic          ack_ready,
    output logic [7:0]    ack_type,
    output logic [5:0]    ack_source,
    output logic [25:0]   ack_tag,
    output logic [63:0]   ack_data,
    input  logic          core_wr_valid,
    output logic          core_wr_ready,
    input  logic [25:0]   core_wr_tag,
    input  logic [63:0]   core_wr_data,
    output logic          unk_err,
    output logic [7:0]    ack_cnt
);

    localparam int IDX_W = $clog2(NUM_LINES);

    rsp_state_t        state, next_state;
    logic [TAG_W-1:0]  lat_tag;
    logic              req_fire, wr_fire, hit;
    logic              rd_valid, rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;

    // Source id is not part of the decode; fold it away explicitly.
    logic unused_src;
    assign unused_src = ^req_source;

    assign req_ready     = ~rst & (state == ST_IDLE);
    assign core_wr_ready = ~rst & (state == ST_IDLE) & ~req_valid;
    assign req_fire      = req_valid & req_ready;
    assign wr_fire       = core_wr_valid & core_wr_ready;
    assign hit           = (state == ST_LOOKUP) & rd_valid & (rd_tag == lat_tag);

    l1_line_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (lat_tag[IDX_W-1:0]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_dirty (rd_dirty),
        .rd_data  (rd_data),
        .inv_en   (hit),
        .inv_idx  (lat_tag[IDX_W-1:0]),
        .wr_en    (wr_fire),
        .wr_idx   (core_wr_tag[IDX_W-1:0]),
        .wr_tag   (core_wr_tag),
        .wr_data  (core_wr_data)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (req_fire && req_type == MSG_INV_FWD) next_state = ST_LOOKUP;
            ST_LOOKUP: next_state = ST_ACK;
            ST_ACK:    if (ack_ready) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignment so every register samples
    // pre-edge values, regardless of the order the statements are written in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            lat_tag   <= '0;
            ack_valid <= 1'b0;
            ack_tag   <= '0;
            unk_err   <= 1'b0;
            ack_cnt   <= '0;
        end else begin
            state     <= next_state;
            ack_valid <= (next_state == ST_ACK);
            unk_err   <= req_fire && (req_type != MSG_INV_FWD);
            if (req_fire && req_type == MSG_INV_FWD) lat_tag <= req_tag;
            if (state == ST_LOOKUP) ack_tag <= lat_tag;
            if (state == ST_ACK && ack_ready && ack_cnt != 8'hFF) ack_cnt <= ack_cnt + 8'd1;
        end
    end

`ifdef L1_INV_WRITEBACK_EN
    logic [DATA_W-1:0] ack_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_data_q <= '0;
        end else if (state == ST_LOOKUP) begin
            ack_data_q <= (hit && rd_dirty) ? rd_data : '0;
        end
    end

    assign ack_data = ack_data_q;
`else
    logic unused_rd;
    assign unused_rd = rd_dirty ^ (^rd_data);
    assign ack_data  = '0;
`endif

    assign ack_type   = MSG_INV_FWDACK;
    assign ack_source = MY_ID;

endmodule

// File: tb/tb_l1_inv_fwd_responder.sv
// Directed self-checking bench for l1_inv_fwd_responder; expected ack data follows
// L1_INV_WRITEBACK_EN the same way the design build does.
module tb_l1_inv_fwd_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_type;
    logic [5:0]  req_source;
    logic [25:0] req_tag;
    logic        ack_valid;
    logic        ack_ready;
    logic [7:0]  ack_type;
    logic [5:0]  ack_source;
    logic [25:0] ack_tag;
    logic [63:0] ack_data;
    logic        core_wr_valid;
    logic        core_wr_ready;
    logic [25:0] core_wr_tag;
    logic [63:0] core_wr_data;
    logic        unk_err;
    logic [7:0]  ack_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    l1_inv_fwd_responder #(
        .NUM_LINES (4),
        .MY_ID     (6'd0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_type      (req_type),
        .req_source    (req_source),
        .req_tag       (req_tag),
        .ack_valid     (ack_valid),
        .ack_ready     (ack_ready),
        .ack_type      (ack_type),
        .ack_source    (ack_source),
        .ack_tag       (ack_tag),
        .ack_data      (ack_data),
        .core_wr_valid (core_wr_valid),
        .core_wr_ready (core_wr_ready),
        .core_wr_tag   (core_wr_tag),
        .core_wr_data  (core_wr_data),
        .unk_err       (unk_err),
        .ack_cnt       (ack_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wb(input logic [63:0] d);
`ifdef L1_INV_WRITEBACK_EN
        return d;
`else
        return 64'h0 & d;
`endif
    endfunction

    task automatic core_write(input logic [25:0] tag, input logic [63:0] data);
        bit done = 0;
        core_wr_valid = 1'b1;
        core_wr_tag   = tag;
        core_wr_data  = data;
        for (int i = 0; i < 20 && !done; i++) begin
            done = core_wr_ready;
            step();
        end
        core_wr_valid = 1'b0;
        if (!done) check("core_wr_timeout", 64'd0, 64'd1);
    endtask

    // Presents one request for a single accepting cycle (caller ensures IDLE).
    task automatic send_req(input logic [7:0] typ, input logic [25:0] tag);
        req_valid = 1'b1;
        req_type  = typ;
        req_tag   = tag;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_ack();
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (ack_valid) seen = 1;
            else step();
        end
        if (!seen) check("ack_timeout", 64'd0, 64'd1);
    endtask

    // Full INV_FWD round trip with ready held high; checks the ack contents.
    task automatic inv_roundtrip(input string tag, input logic [25:0] line, input logic [63:0] exp_data);
        ack_ready = 1'b1;
        send_req(8'h16, line);
        wait_ack();
        check({tag, "_tag"},  {38'd0, ack_tag}, {38'd0, line});
        check({tag, "_data"}, ack_data, exp_data);
        step();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_type = '0; req_source = 6'd3; req_tag = '0;
        ack_ready = 1'b0;
        core_wr_valid = 1'b0; core_wr_tag = '0; core_wr_data = '0;
        step();
        check("rst_req_ready",   {63'd0, req_ready}, 64'd0);
        check("rst_wr_ready",    {63'd0, core_wr_ready}, 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("rst_ack_valid",   {63'd0, ack_valid}, 64'd0);
        check("rst_ack_tag",     {38'd0, ack_tag}, 64'd0);
        check("rst_ack_data",    ack_data, 64'd0);
        check("rst_unk_err",     {63'd0, unk_err}, 64'd0);
        check("rst_ack_cnt",     {56'd0, ack_cnt}, 64'd0);
        check("idle_req_ready",  {63'd0, req_ready}, 64'd1);

        // Dirty hit: ack exactly two cycles after accept.
        core_write(26'h0000123, 64'hDEADBEEF);
        req_valid = 1'b1; req_type = 8'h16; req_tag = 26'h0000123;
        step();
        req_valid = 1'b0;
        check("n1_ack_valid",    {63'd0, ack_valid}, 64'd0);
        check("n1_req_ready",    {63'd0, req_ready}, 64'd0);
        step();
        check("n2_ack_valid",    {63'd0, ack_valid}, 64'd1);
        check("n2_ack_type",     {56'd0, ack_type}, 64'h17);
        check("n2_ack_source",   {58'd0, ack_source}, 64'd0);
        check("n2_ack_tag",      {38'd0, ack_tag}, 64'h123);
        check("n2_ack_data",     ack_data, wb(64'hDEADBEEF));
        ack_ready = 1'b1;
        step();
        check("hs_ack_valid",    {63'd0, ack_valid}, 64'd0);
        check("hs_ack_cnt",      {56'd0, ack_cnt}, 64'd1);
        check("hs_req_ready",    {63'd0, req_ready}, 64'd1);

        // The line was invalidated, so a repeat is a miss; then an empty index.
        inv_roundtrip("reinv", 26'h0000123, 64'd0);
        inv_roundtrip("empty", 26'h0000044, 64'd0);
        check("empty_ack_cnt",   {56'd0, ack_cnt}, 64'd3);

        // Backpressure: ack held for 5 cycles with all fields stable.
        core_write(26'h0000005, 64'h0123456789ABCDEF);
        ack_ready = 1'b0;
        send_req(8'h16, 26'h0000005);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_ack_valid", {63'd0, ack_valid}, 64'd1);
            check("bp_ack_tag",   {38'd0, ack_tag}, 64'h5);
            check("bp_ack_data",  ack_data, wb(64'h0123456789ABCDEF));
            check("bp_req_ready", {63'd0, req_ready}, 64'd0);
            step();
        end
        check("bp_cnt_held",     {56'd0, ack_cnt}, 64'd3);
        ack_ready = 1'b1;
        step();
        check("bp_ack_done",     {63'd0, ack_valid}, 64'd0);
        check("bp_ack_cnt",      {56'd0, ack_cnt}, 64'd4);

        // Same-cycle contest: the request wins, the write lands after the ack.
        req_valid = 1'b1; req_type = 8'h16; req_tag = 26'h0000007;
        core_wr_valid = 1'b1; core_wr_tag = 26'h0000007; core_wr_data = 64'h55;
        #1;
        check("contest_wr_ready", {63'd0, core_wr_ready}, 64'd0);
        check("contest_req_ready", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
        #1;
        check("lookup_wr_ready", {63'd0, core_wr_ready}, 64'd0);
        wait_ack();
        check("contest_ack_data", ack_data, 64'd0);
        step();
        check("after_ack_wr_ready", {63'd0, core_wr_ready}, 64'd1);
        step();
        core_wr_valid = 1'b0;
        inv_roundtrip("late_wr", 26'h0000007, wb(64'h55));
        check("late_wr_cnt",     {56'd0, ack_cnt}, 64'd6);

        // Unknown type: accepted, one unk_err pulse, no ack.
        send_req(8'h05, 26'h0000001);
        check("unk_err_pulse",   {63'd0, unk_err}, 64'd1);
        check("unk_req_ready",   {63'd0, req_ready}, 64'd1);
        step();
        check("unk_err_clear",   {63'd0, unk_err}, 64'd0);
        check("unk_no_ack",      {63'd0, ack_valid}, 64'd0);
        step();
        check("unk_no_ack2",     {63'd0, ack_valid}, 64'd0);
        check("unk_ack_cnt",     {56'd0, ack_cnt}, 64'd6);

        // Reset while an ack is pending abandons it and clears the store.
        core_write(26'h0000009, 64'hCAFE);
        ack_ready = 1'b0;
        send_req(8'h16, 26'h0000002);
        step();
        check("pre_rst_ack_valid", {63'd0, ack_valid}, 64'd1);
        rst = 1'b1;
        step();
        check("mid_rst_ack_valid", {63'd0, ack_valid}, 64'd0);
        check("mid_rst_ack_cnt",   {56'd0, ack_cnt}, 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_ack_valid", {63'd0, ack_valid}, 64'd0);
        inv_roundtrip("post_rst", 26'h0000009, 64'd0);
        check("post_rst_cnt",    {56'd0, ack_cnt}, 64'd1);

        // Back-to-back acks saturate the counter at 255.
        for (int i = 0; i < 300; i++) begin
            send_req(8'h16, 26'(i));
            wait_ack();
            step();
            if (i == 253) check("cnt_254", {56'd0, ack_cnt}, 64'd255);
        end
        check("cnt_saturated",   {56'd0, ack_cnt}, 64'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
